idct_transpose: RTL and testbench
=================================

# idct_transpose

Ping-pong 8x8 transpose buffer between the row IDCT (`rowidct`) and the column IDCT stage. It accepts one 8-word row per cycle, driven by `rowidct`'s `rdy`, and stores each block of eight rows. Once a block is complete, it emits that block as eight 8-word columns under a valid/ready handshake. Two banks allow one block to be written while the previous block drains, so the pipeline sustains one row in and one column out per cycle.

## Interface
- `W`, 32, signed word width of every data port and buffer entry.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low. Low clears all state immediately.
- `x0`..`x7`  in  W each  signed row words from `rowidct` (`y0`..`y7` there).
- `in_valid`  in  1  row present on `x0`..`x7`; tied to `rowidct` `rdy`.
- `in_ready`  out  1  buffer can accept a row this cycle.
- `y0`..`y7`  out  W each  signed column words; `yk` = row k of current column.
- `out_valid`  out  1  column present on `y0`..`y7`.
- `out_ready`  in  1  column stage accepts column this cycle.
- `out_col`  out  3  index (0..7) of the column currently presented.
- `out_last`  out  1  high when `out_valid` is high and `out_col` = 7.

## Operation
- State:
  - two banks B0/B1, each 8x8 words of W bits;
  - `full[1:0]`;
  - `wr_bank`, `wr_row[2:0]`;
  - `rd_bank`, `rd_col[2:0]`.
- Write side:
  - `in_ready` = !`full[wr_bank]`.
  - Accept occurs when `in_valid` && `in_ready`.
  - On accept, store B[`wr_bank`][`wr_row`][k] <= `xk` for k = 0..7, then increment `wr_row`.
  - On accept with `wr_row` = 7: `wr_row` wraps to 0, `full[wr_bank]` <= 1, `wr_bank` toggles.
  - `in_valid` while `in_ready` is low: the row is not stored. The upstream stage must hold it.
- Read side:
  - `out_valid` = `full[rd_bank]`.
  - `yk` = B[`rd_bank`][k][`rd_col`]. All `y` outputs read 0 when `out_valid` is low.
  - `out_col` = `rd_col`.
  - Transfer occurs when `out_valid` && `out_ready`; on transfer, increment `rd_col`.
  - On transfer with `rd_col` = 7: `rd_col` wraps to 0, `full[rd_bank]` <= 0, `rd_bank` toggles.
- No bank is ever written and read at once: writes need !full, reads need full.
- Simultaneous events:
  - A write completing bank A and a read completing bank B on the same edge both take effect.
  - A `full` bit set and cleared on the same edge always refers to different banks.
- No bypass: a bank freed at edge t raises `in_ready` only after t, never in the same cycle.
- Blocks leave in arrival order. Values pass through bit-exact, sign preserved; no arithmetic or saturation.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_last` = 0, `out_col` = 0, `y0`..`y7` = 0.
  - Also reset: `full` = 00, `wr_bank` = `rd_bank` = 0, `wr_row` = `rd_col` = 0.
  - Bank contents need not be cleared; they are invisible while `out_valid` is low.
- Reset asserted mid-block: any partial rows and pending full blocks are discarded. The first row accepted after release is row 0 of a new block in B0.
- Latency: if the 8th row of a block is accepted at edge t, `out_valid` is high in the cycle after t with column 0.
- Throughput:
  - With `out_ready` held high and `in_valid` continuous, `in_ready` never drops.
  - One column leaves per cycle and one row enters per cycle.
- Fill limit: with `out_ready` low, exactly 16 rows are accepted, then `in_ready` = 0.
- Outputs are stable while `out_valid` = 1 and `out_ready` = 0.

## Test plan
- Reset check: drive `reset` low asynchronously between edges.
  - Outputs go to their reset values without waiting for a clock edge.
  - After release: `in_ready` = 1, `out_valid` = 0.
- Single block:
  - Stimulus: 8 rows r = 0..7 with `xk` = 8r+k, `out_ready` = 1.
  - `out_valid` rises the cycle after the 8th accept.
  - Column c presents `yk` = 8k+c; column 0 = 0, 8, 16, …, 56; column 7 = 7, 15, …, 63.
  - `out_last` is high only on column 7.
- Backpressure:
  - Stimulus: `out_ready` = 0 while 17 rows are offered.
  - `in_ready` falls after the 16th accept, and row 17 waits.
  - Then raise `out_ready`: after 8 column transfers, `in_ready` = 1 on the following cycle and row 17 is accepted as row 0.
- Streaming: 3 back-to-back blocks with signed data, including -1 and -2^31, and `out_ready` = 1.
  - No input bubble.
  - All 24 columns come out in order with exact signed values.
- Random stalls: toggle `out_ready` pseudo-randomly.
  - `y0`..`y7` and `out_col` hold while stalled.
  - No column is skipped or duplicated.
- Mid-block reset: pull `reset` low after 5 rows of a block.
  - `out_valid` stays 0.
  - The next 8 rows form a fresh block, and its column 0 equals the new row-0..7 words.

Source files
------------

// File: rtl/idct_transpose_if.sv
// Row-in / column-out bus between the row IDCT, the transpose buffer and the column IDCT.
// master: the surrounding pipeline (drives rows, accepts columns); slave: the transpose buffer.
interface idct_transpose_if;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 3;

  logic signed [W-1:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic                 in_valid;
  logic                 in_ready;

  logic signed [W-1:0]  y0, y1, y2, y3, y4, y5, y6, y7;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_col;
  logic                 out_last;

  modport master (
    output x0, x1, x2, x3, x4, x5, x6, x7,
    output in_valid,
    input  in_ready,
    input  y0, y1, y2, y3, y4, y5, y6, y7,
    input  out_valid,
    output out_ready,
    input  out_col,
    input  out_last
  );

  modport slave (
    input  x0, x1, x2, x3, x4, x5, x6, x7,
    input  in_valid,
    output in_ready,
    output y0, y1, y2, y3, y4, y5, y6, y7,
    output out_valid,
    input  out_ready,
    output out_col,
    output out_last
  );
endinterface

// File: rtl/idct_transpose.sv
// Ping-pong 8x8 transpose buffer: rows in from the row IDCT, columns out to the column IDCT.
// One bank fills while the other drains; blocks leave in arrival order, bit-exact.
module idct_transpose (
  input  logic            clk,
  input  logic            reset,
  idct_transpose_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned NB = 2;

  typedef logic signed [W-1:0] word_t;
  typedef word_t [N-1:0]       row_t;

  // Storage is never reset: its contents are only visible while out_valid is high.
  row_t          bank_q [NB][N];

  logic [NB-1:0] full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_row_q, wr_row_d;
  logic [IW-1:0] rd_col_q, rd_col_d;

  logic          in_ready_c;
  logic          out_valid_c;
  logic          wr_en;
  logic          rd_en;
  row_t          row_in;
  row_t          col_out;

  assign row_in = {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};

  // Handshake decode and next-state; a bank is written only when empty and read only when full.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_row_d    = wr_row_q;
    rd_col_d    = rd_col_q;

    in_ready_c  = !full_q[wr_bank_q];
    out_valid_c = full_q[rd_bank_q];
    wr_en       = bus.in_valid && in_ready_c;
    rd_en       = out_valid_c && bus.out_ready;

    if (wr_en) begin
      wr_row_d = wr_row_q + IW'(1);
      if (wr_row_q == IW'(N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // The bank being drained is never the bank being completed, so both updates can coexist.
    if (rd_en) begin
      rd_col_d = rd_col_q + IW'(1);
      if (rd_col_q == IW'(N - 1)) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_bank_q][wr_row_q] <= row_in;
    end
  end

  // Column gather: word k of the output is row k of the draining bank at the current column.
  always_comb begin
    col_out = '0;
    if (out_valid_c) begin
      for (int k = 0; k < N; k++) begin
        col_out[IW'(k)] = bank_q[rd_bank_q][IW'(k)][rd_col_q];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_col   = rd_col_q;
  assign bus.out_last  = out_valid_c && (rd_col_q == IW'(N - 1));

  assign bus.y0 = col_out[0];
  assign bus.y1 = col_out[1];
  assign bus.y2 = col_out[2];
  assign bus.y3 = col_out[3];
  assign bus.y4 = col_out[4];
  assign bus.y5 = col_out[5];
  assign bus.y6 = col_out[6];
  assign bus.y7 = col_out[7];

endmodule

// File: tb/tb_idct_transpose.sv
// Bench for idct_transpose: directed table, hand sequences for the multi-cycle corners,
// and random traffic checked against a queue-of-rows reference model.
module tb_idct_transpose;
  typedef logic signed [31:0] word_t;

  typedef struct {
    logic  in_valid;
    int    base;
    logic  out_ready;
    logic  exp_in_ready;
    logic  exp_out_valid;
    int    exp_col;
    logic  exp_last;
    word_t exp_y0;
    word_t exp_y7;
  } vec_t;

  logic clk;
  logic reset;

  idct_transpose_if bus ();

  idct_transpose dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;

  // Model: every accepted row word in arrival order; front 64 words = oldest complete block.
  word_t rows_q [$];
  int    head_col = 0;
  word_t cur_x [8];
  vec_t  vecs [17];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint get_y(input int k);
    case (k)
      0: return longint'(bus.y0);
      1: return longint'(bus.y1);
      2: return longint'(bus.y2);
      3: return longint'(bus.y3);
      4: return longint'(bus.y4);
      5: return longint'(bus.y5);
      6: return longint'(bus.y6);
      default: return longint'(bus.y7);
    endcase
  endfunction

  task automatic drive(input logic v, input logic r);
    bus.in_valid  = v;
    bus.out_ready = r;
    bus.x0 = cur_x[0]; bus.x1 = cur_x[1]; bus.x2 = cur_x[2]; bus.x3 = cur_x[3];
    bus.x4 = cur_x[4]; bus.x5 = cur_x[5]; bus.x6 = cur_x[6]; bus.x7 = cur_x[7];
  endtask

  task automatic apply(input logic v, input logic r);
    drive(v, r);
    #1;
  endtask

  task automatic check_model();
    int     nfull;
    longint ey;
    nfull = rows_q.size() / 64;
    chk("in_ready",  longint'(bus.in_ready),  longint'(nfull < 2));
    chk("out_valid", longint'(bus.out_valid), longint'(nfull > 0));
    chk("out_col",   longint'(bus.out_col),   (nfull > 0) ? longint'(head_col) : 0);
    chk("out_last",  longint'(bus.out_last),  longint'(nfull > 0 && head_col == 7));
    for (int k = 0; k < 8; k++) begin
      ey = (nfull > 0) ? longint'(rows_q[8*k + head_col]) : 0;
      chk($sformatf("y%0d", k), get_y(k), ey);
    end
  endtask

  // Model update for the coming edge, then move to the next falling edge.
  task automatic advance(output bit acc);
    int nfull;
    bit xfer;
    nfull = rows_q.size() / 64;
    acc   = bus.in_valid  && (nfull < 2);
    xfer  = bus.out_ready && (nfull > 0);
    if (xfer) begin
      if (head_col == 7) begin
        repeat (64) void'(rows_q.pop_front());
        head_col = 0;
      end else begin
        head_col++;
      end
    end
    if (acc) begin
      for (int k = 0; k < 8; k++) rows_q.push_back(cur_x[k]);
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic r, output bit acc);
    apply(v, r);
    check_model();
    advance(acc);
  endtask

  task automatic new_row();
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       cur_x[k] = -32'sd1;
        1:       cur_x[k] = 32'sh8000_0000;
        default: cur_x[k] = word_t'($urandom);
      endcase
    end
  endtask

  // Reset pulled low between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready",  longint'(bus.in_ready),  1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_col",   longint'(bus.out_col),   0);
    chk("rst_out_last",  longint'(bus.out_last),  0);
    chk("rst_y0",        longint'(bus.y0),        0);
    chk("rst_y7",        longint'(bus.y7),        0);
    rows_q.delete();
    head_col = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_random(input int n, input int pv, input int pr);
    bit   acc;
    logic v;
    v = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!v) v = ($urandom_range(0, 99) < pv);
      cycle(v, ($urandom_range(0, 99) < pr), acc);
      if (acc) begin
        new_row();
        v = 1'b0;
      end
    end
  endtask

  initial begin
    bit acc;
    int cnt;

    reset = 1'b0;
    for (int k = 0; k < 8; k++) cur_x[k] = '0;
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("init_in_ready",  longint'(bus.in_ready),  1);
    chk("init_out_valid", longint'(bus.out_valid), 0);
    @(negedge clk);

    // Single block: row r carries 8r+k, so column c must read 8k+c.
    for (int i = 0; i < 17; i++) begin
      vecs[i].out_ready    = 1'b1;
      vecs[i].exp_in_ready = 1'b1;
      if (i < 8) begin
        vecs[i].in_valid      = 1'b1;
        vecs[i].base          = 8 * i;
        vecs[i].exp_out_valid = 1'b0;
        vecs[i].exp_col       = 0;
        vecs[i].exp_last      = 1'b0;
        vecs[i].exp_y0        = '0;
        vecs[i].exp_y7        = '0;
      end else if (i < 16) begin
        vecs[i].in_valid      = 1'b0;
        vecs[i].base          = 0;
        vecs[i].exp_out_valid = 1'b1;
        vecs[i].exp_col       = i - 8;
        vecs[i].exp_last      = (i == 15);
        vecs[i].exp_y0        = word_t'(i - 8);
        vecs[i].exp_y7        = word_t'(56 + i - 8);
      end else begin
        vecs[i].in_valid      = 1'b0;
        vecs[i].base          = 0;
        vecs[i].exp_out_valid = 1'b0;
        vecs[i].exp_col       = 0;
        vecs[i].exp_last      = 1'b0;
        vecs[i].exp_y0        = '0;
        vecs[i].exp_y7        = '0;
      end
    end

    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 8; k++) cur_x[k] = word_t'(vecs[i].base + k);
      apply(vecs[i].in_valid, vecs[i].out_ready);
      check_model();
      chk($sformatf("tbl%0d_in_ready", i),  longint'(bus.in_ready),  longint'(vecs[i].exp_in_ready));
      chk($sformatf("tbl%0d_out_valid", i), longint'(bus.out_valid), longint'(vecs[i].exp_out_valid));
      chk($sformatf("tbl%0d_out_col", i),   longint'(bus.out_col),   longint'(vecs[i].exp_col));
      chk($sformatf("tbl%0d_out_last", i),  longint'(bus.out_last),  longint'(vecs[i].exp_last));
      chk($sformatf("tbl%0d_y0", i),        longint'(bus.y0),        longint'(vecs[i].exp_y0));
      chk($sformatf("tbl%0d_y7", i),        longint'(bus.y7),        longint'(vecs[i].exp_y7));
      advance(acc);
    end

    // Asynchronous reset with a complete block pending.
    new_row();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, acc);
      if (acc) new_row();
    end
    async_reset();
    cycle(1'b0, 1'b0, acc);

    // Backpressure: 16 rows fill both banks, the 17th must wait.
    new_row();
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 1'b0, acc);
      if (acc) begin
        cnt++;
        new_row();
      end
    end
    chk("bp_accepts", longint'(cnt), 16);
    apply(1'b1, 1'b0);
    chk("bp_in_ready_low", longint'(bus.in_ready), 0);
    check_model();
    advance(acc);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, acc);
      if (acc) cnt++;
    end
    chk("bp_no_bypass", longint'(cnt), 0);
    apply(1'b1, 1'b1);
    chk("bp_reopen", longint'(bus.in_ready), 1);
    check_model();
    advance(acc);
    if (acc) new_row();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, acc);

    // Streaming: continuous rows and columns, never a bubble on the input.
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 1'b1, acc);
      if (acc) begin
        cnt++;
        new_row();
      end
    end
    chk("stream_accepts", longint'(cnt), 24);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, acc);

    // Random valid and ready.
    run_random(400, 70, 50);

    // Mid-block reset after 5 rows; the next 8 rows form a fresh block.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, acc);
      if (acc) new_row();
    end
    async_reset();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) cur_x[k] = word_t'(100 * r + k);
      apply(1'b1, 1'b0);
      chk("mbr_out_valid_low", longint'(bus.out_valid), 0);
      check_model();
      advance(acc);
    end
    apply(1'b0, 1'b0);
    check_model();
    chk("mbr_out_valid", longint'(bus.out_valid), 1);
    chk("mbr_y0", longint'(bus.y0), 0);
    chk("mbr_y1", longint'(bus.y1), 100);
    chk("mbr_y7", longint'(bus.y7), 700);
    advance(acc);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
